sram22_arb2_1024x8: RTL and testbench
=====================================

SRAM22_ARB2_1024X8 -- requirements
Module: sram22_arb2_1024x8

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 10, word address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, word width.
REQ-003 SHALL have parameter WMASK_WIDTH, default 8, per-bit write mask width.
REQ-004 SHALL have port clk, input, 1, single clock; all logic on rising edge.
REQ-005 SHALL have port rst, input, 1, reset, synchronous, active-high.
REQ-006 SHALL have ports reqN_valid, input, 1, and reqN_ready, output, 1, for N=0,1: request handshake.
REQ-007 SHALL have ports reqN_we (1), reqN_wmask (WMASK_WIDTH), reqN_addr (ADDR_WIDTH) and reqN_din (DATA_WIDTH), all inputs, for N=0,1: request payload.
REQ-008 SHALL have ports rspN_valid, output, 1, and rspN_rdata, output, DATA_WIDTH, for N=0,1: read response.
REQ-009 SHALL have port init_done, output, 1, high when requests can be accepted.
REQ-010 SHALL have SRAM-side ports sram_rstb, sram_ce and sram_we (outputs, 1), sram_wmask (output, WMASK_WIDTH), sram_addr (output, ADDR_WIDTH), sram_din (output, DATA_WIDTH) and sram_dout (input, DATA_WIDTH).

Function
REQ-011 SHALL share one single-port SRAM macro between requesters 0 and 1, with at most one SRAM command per cycle.
REQ-012 SHALL complete a request transfer when reqN_valid and reqN_ready are both high on the same rising edge.
REQ-013 SHALL drive reqN_ready combinationally: high only when init_done=1, reqN_valid=1 and port N wins arbitration.
REQ-014 SHALL grant by round-robin: a lone valid port wins; with both valid, the port named by the priority pointer wins.
REQ-015 SHALL move the priority pointer to the other port after each completed transfer, and SHALL NOT move it otherwise.
REQ-016 SHALL drive the SRAM in the transfer cycle: sram_ce=1, with sram_we, sram_wmask, sram_addr and sram_din taken from the granted port.
REQ-017 SHALL drive sram_ce=0 in cycles with no transfer and no init write; the other SRAM outputs are then don't-care.
REQ-018 SHALL, for a read (we=0) accepted at edge T, assert rspN_valid for exactly the cycle after T, with rspN_rdata=sram_dout; N is the granted port.
REQ-019 SHALL generate no response for a write (we=1).
REQ-020 SHALL make responses non-stallable; back-to-back reads give back-to-back single-cycle pulses in grant order.
REQ-021 SHALL make a read that follows a write to the same address return the written data, since the SRAM orders commands.
REQ-022 SHALL hold rspN_rdata stable while rspN_valid=0; its value is then don't-care.
REQ-023 SHALL drive sram_rstb = ~rst.

Reset
REQ-024 SHALL, while rst=1, force: rsp0_valid=0, rsp1_valid=0, sram_ce=0, req0_ready=0, req1_ready=0, priority pointer=port 0, init_done=0.
REQ-025 SHALL, when rst is asserted mid-operation, drop an outstanding read response and restart initialisation from word 0 if SRAM22_ARB_INIT_EN is defined.

Configuration
REQ-026 SHALL use macro SRAM22_ARB_INIT_EN to compile in the zero-initialisation feature.
REQ-027 SHALL, with SRAM22_ARB_INIT_EN defined, implement an FSM with states INIT and RUN, entering INIT on reset.
REQ-028 SHALL, in INIT, write din=0 with wmask all-ones to addresses 0..RAM_DEPTH-1, one word per cycle, using an ADDR_WIDTH-bit counter; reqN_ready=0 throughout.
REQ-029 SHALL, in INIT, move to RUN and set init_done=1 in the cycle after the write to address RAM_DEPTH-1, when the counter wraps to 0.
REQ-030 SHALL, without SRAM22_ARB_INIT_EN, have no INIT state or counter, and set init_done=1 in the first cycle after rst deasserts.

Structure
REQ-031 SHALL place the width defaults, RAM_DEPTH (1<<ADDR_WIDTH) and the FSM state enum in package sram22_arb_pkg.
REQ-032 SHALL implement the grant logic and priority pointer in sub-module sram22_rr_arb2.
REQ-033 SHALL keep the response-port tag and the response-valid register in the top module.

Verification
REQ-034 SHALL cover: only req0 writes addr 0x005, din 0xA5, wmask 0xFF; then req0 reads 0x005 -> rsp0_valid pulses one cycle after accept with 0xA5, and rsp1_valid stays 0.
REQ-035 SHALL cover: req0 and req1 both valid every cycle after reset, reading distinct addresses -> grants alternate 0,1,0,1; each rspN arrives one cycle after its own grant.
REQ-036 SHALL cover: word 0x3FF=0x00, req1 writes din 0xFF with wmask 0x0F, then reads 0x3FF -> rdata 0x0F.
REQ-037 SHALL cover, with SRAM22_ARB_INIT_EN: release reset -> init_done rises exactly 1024 cycles later; a read of any address then returns 0x00.
REQ-038 SHALL cover: assert rst for 1 cycle while a read is in flight -> no rsp pulse; pointer returns to 0; INIT restarts at address 0 (with macro).
REQ-039 SHALL cover: reqN_valid held high while init_done=0 -> reqN_ready=0 and sram_we from requests never asserted.

Source files
------------

// File: rtl/sram22_arb_pkg.sv
// Shared widths, depth and controller state type for the two-port sram22 arbiter.
package sram22_arb_pkg;

  localparam int ADDR_WIDTH_DEF  = 10;
  localparam int DATA_WIDTH_DEF  = 8;
  localparam int WMASK_WIDTH_DEF = 8;
  localparam int RAM_DEPTH       = 1 << ADDR_WIDTH_DEF;

  typedef enum logic {
    INIT,
    RUN
  } arb_state_t;

endpackage

// File: rtl/sram22_rr_arb2.sv
// Two-way round-robin grant with a priority pointer that flips away from each winner.
module sram22_rr_arb2 (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic valid0,
  input  logic valid1,
  output logic grant0,
  output logic grant1,
  output logic winner
);

  logic prio;

  // A lone requester always wins; the pointer only breaks ties.
  always_comb begin
    winner = (valid0 && valid1) ? prio : valid1;
    grant0 = en & valid0 & ~winner;
    grant1 = en & valid1 & winner;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prio <= 1'b0;
    end else if (grant0 | grant1) begin
      prio <= ~winner;
    end
  end

endmodule

// File: rtl/sram22_arb2_1024x8.sv
// Shares one single-port sram22 macro between two requesters with round-robin grant.
// Define SRAM22_ARB_INIT_EN to zero the whole array after every reset before accepting requests.
module sram22_arb2_1024x8
  import sram22_arb_pkg::*;
#(
  parameter int ADDR_WIDTH  = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int WMASK_WIDTH = WMASK_WIDTH_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req0_valid,
  output logic                   req0_ready,
  input  logic                   req0_we,
  input  logic [WMASK_WIDTH-1:0] req0_wmask,
  input  logic [ADDR_WIDTH-1:0]  req0_addr,
  input  logic [DATA_WIDTH-1:0]  req0_din,
  input  logic                   req1_valid,
  output logic                   req1_ready,
  input  logic                   req1_we,
  input  logic [WMASK_WIDTH-1:0] req1_wmask,
  input  logic [ADDR_WIDTH-1:0]  req1_addr,
  input  logic [DATA_WIDTH-1:0]  req1_din,
  output logic                   rsp0_valid,
  output logic [DATA_WIDTH-1:0]  rsp0_rdata,
  output logic                   rsp1_valid,
  output logic [DATA_WIDTH-1:0]  rsp1_rdata,
  output logic                   init_done,
  output logic                   sram_rstb,
  output logic                   sram_ce,
  output logic                   sram_we,
  output logic [WMASK_WIDTH-1:0] sram_wmask,
  output logic [ADDR_WIDTH-1:0]  sram_addr,
  output logic [DATA_WIDTH-1:0]  sram_din,
  input  logic [DATA_WIDTH-1:0]  sram_dout
);

  logic                   init_done_q;
  logic                   init_wr;
  logic [ADDR_WIDTH-1:0]  init_addr;
  logic                   grant0, grant1, winner, xfer;
  logic                   g_we;
  logic [WMASK_WIDTH-1:0] g_wmask;
  logic [ADDR_WIDTH-1:0]  g_addr;
  logic [DATA_WIDTH-1:0]  g_din;
  logic                   rsp_valid_q, rsp_port_q;
  logic [DATA_WIDTH-1:0]  hold0, hold1;

  sram22_rr_arb2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .en     (init_done_q & ~rst),
    .valid0 (req0_valid),
    .valid1 (req1_valid),
    .grant0 (grant0),
    .grant1 (grant1),
    .winner (winner)
  );

  assign xfer       = grant0 | grant1;
  assign req0_ready = grant0;
  assign req1_ready = grant1;

  assign g_we    = winner ? req1_we    : req0_we;
  assign g_wmask = winner ? req1_wmask : req0_wmask;
  assign g_addr  = winner ? req1_addr  : req0_addr;
  assign g_din   = winner ? req1_din   : req0_din;

`ifdef SRAM22_ARB_INIT_EN
  arb_state_t state;

  // Sweep every word once, then hand the macro over to the requesters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= INIT;
      init_addr   <= '0;
      init_done_q <= 1'b0;
    end else begin
      case (state)
        INIT: begin
          init_addr <= init_addr + 1'b1;
          if (init_addr == '1) begin
            state       <= RUN;
            init_done_q <= 1'b1;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

  assign init_wr = (state == INIT) & ~rst;
`else
  always_ff @(posedge clk) begin
    if (rst) begin
      init_done_q <= 1'b0;
    end else begin
      init_done_q <= 1'b1;
    end
  end

  assign init_wr   = 1'b0;
  assign init_addr = '0;
`endif

  assign sram_rstb  = ~rst;
  assign sram_ce    = init_wr | xfer;
  assign sram_we    = init_wr | (xfer & g_we);
  assign sram_wmask = init_wr ? '1        : g_wmask;
  assign sram_addr  = init_wr ? init_addr : g_addr;
  assign sram_din   = init_wr ? '0        : g_din;
  assign init_done  = init_done_q & ~rst;

  // The macro returns read data one cycle after the command, so tag who asked.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_q <= 1'b0;
      rsp_port_q  <= 1'b0;
    end else begin
      rsp_valid_q <= xfer & ~g_we;
      rsp_port_q  <= winner;
    end
  end

  assign rsp0_valid = rsp_valid_q & ~rsp_port_q & ~rst;
  assign rsp1_valid = rsp_valid_q &  rsp_port_q & ~rst;

  // Capture the last delivered word so rdata stays put between pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold0 <= '0;
      hold1 <= '0;
    end else begin
      if (rsp0_valid) hold0 <= sram_dout;
      if (rsp1_valid) hold1 <= sram_dout;
    end
  end

  assign rsp0_rdata = rsp0_valid ? sram_dout : hold0;
  assign rsp1_rdata = rsp1_valid ? sram_dout : hold1;

endmodule

// File: tb/tb_sram22_arb2_1024x8.sv
// Self-checking bench: behavioural sram22 macro, per-cycle reference model and directed scenarios.
module tb_sram22_arb2_1024x8;

  localparam int DEPTH = 1024;
`ifdef SRAM22_ARB_INIT_EN
  localparam int INIT_CYCLES = 1024;
`else
  localparam int INIT_CYCLES = 1;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid, req0_ready, req0_we;
  logic [7:0] req0_wmask, req0_din;
  logic [9:0] req0_addr;
  logic       req1_valid, req1_ready, req1_we;
  logic [7:0] req1_wmask, req1_din;
  logic [9:0] req1_addr;
  logic       rsp0_valid, rsp1_valid;
  logic [7:0] rsp0_rdata, rsp1_rdata;
  logic       init_done;
  logic       sram_rstb, sram_ce, sram_we;
  logic [7:0] sram_wmask, sram_din, sram_dout;
  logic [9:0] sram_addr;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  sram22_arb2_1024x8 dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_we    (req0_we),
    .req0_wmask (req0_wmask),
    .req0_addr  (req0_addr),
    .req0_din   (req0_din),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_we    (req1_we),
    .req1_wmask (req1_wmask),
    .req1_addr  (req1_addr),
    .req1_din   (req1_din),
    .rsp0_valid (rsp0_valid),
    .rsp0_rdata (rsp0_rdata),
    .rsp1_valid (rsp1_valid),
    .rsp1_rdata (rsp1_rdata),
    .init_done  (init_done),
    .sram_rstb  (sram_rstb),
    .sram_ce    (sram_ce),
    .sram_we    (sram_we),
    .sram_wmask (sram_wmask),
    .sram_addr  (sram_addr),
    .sram_din   (sram_din),
    .sram_dout  (sram_dout)
  );

  // Behavioural macro: synchronous read, per-bit masked write, non-zero power-up contents.
  logic [7:0] sramMem [DEPTH];
  bit         sramFilled = 1'b0;

  always @(posedge clk) begin
    if (!sramFilled) begin
      for (int i = 0; i < DEPTH; i++) sramMem[i] <= 8'(i) ^ 8'h5C;
      sramFilled <= 1'b1;
    end else if (sram_rstb && sram_ce) begin
      if (sram_we)
        sramMem[sram_addr] <= (sramMem[sram_addr] & ~sram_wmask) | (sram_din & sram_wmask);
      else
        sram_dout <= sramMem[sram_addr];
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
  endtask

  task automatic applyStimulus(input int port, input logic v, input logic we, input logic [7:0] mask,
                               input logic [9:0] addr, input logic [7:0] din);
    if (port == 0) begin
      req0_valid = v; req0_we = we; req0_wmask = mask; req0_addr = addr; req0_din = din;
    end else begin
      req1_valid = v; req1_we = we; req1_wmask = mask; req1_addr = addr; req1_din = din;
    end
  endtask

  // One accepted transfer on a single port; returns just after the accepting edge.
  task automatic singleXfer(input string name, input int port, input logic we, input logic [7:0] mask,
                            input logic [9:0] addr, input logic [7:0] din);
    @(posedge clk); #1;
    applyStimulus(port, 1'b1, we, mask, addr, din);
    @(negedge clk);
    checkOutput(name, (port == 0) ? req0_ready : req1_ready, 1);
    @(posedge clk); #1;
    applyStimulus(port, 1'b0, 1'b0, 8'h00, 10'h000, 8'h00);
  endtask

  // Reference model: memory contents, pointer and pending response, advanced once per cycle.
  logic [7:0] mMem [DEPTH];
  bit         mKnown [DEPTH];
  bit         mInitDone, mPtr, mPendV, mPendPort, mPendKnown;
  int         mInitCnt;
  logic [7:0] mPendData;

  always @(negedge clk) begin : compare
    bit         anyG, win, nPV, nPP, nPK;
    logic [7:0] nPD, wm, wd;
    logic [9:0] wa;
    logic       ww;
    checkOutput("sram_rstb", sram_rstb, !rst);
    if (rst) begin
      checkOutput("rst_req0_ready", req0_ready, 0);
      checkOutput("rst_req1_ready", req1_ready, 0);
      checkOutput("rst_rsp0_valid", rsp0_valid, 0);
      checkOutput("rst_rsp1_valid", rsp1_valid, 0);
      checkOutput("rst_sram_ce", sram_ce, 0);
      checkOutput("rst_init_done", init_done, 0);
      mPtr = 0; mPendV = 0; mInitDone = 0; mInitCnt = 0;
    end else begin
      nPV = 0; nPP = 0; nPK = 0; nPD = 8'h00;
      checkOutput("init_done", init_done, mInitDone);
      checkOutput("rsp0_valid", rsp0_valid, mPendV && !mPendPort);
      checkOutput("rsp1_valid", rsp1_valid, mPendV && mPendPort);
      if (mPendV && mPendKnown)
        checkOutput(mPendPort ? "rsp1_rdata" : "rsp0_rdata", mPendPort ? rsp1_rdata : rsp0_rdata, mPendData);
      if (!mInitDone) begin
        checkOutput("init_req0_ready", req0_ready, 0);
        checkOutput("init_req1_ready", req1_ready, 0);
`ifdef SRAM22_ARB_INIT_EN
        checkOutput("init_sram_ce", sram_ce, 1);
        checkOutput("init_sram_we", sram_we, 1);
        checkOutput("init_sram_wmask", sram_wmask, 8'hFF);
        checkOutput("init_sram_addr", sram_addr, mInitCnt);
        checkOutput("init_sram_din", sram_din, 0);
        mMem[mInitCnt] = 8'h00;
        mKnown[mInitCnt] = 1;
        mInitCnt++;
        if (mInitCnt == DEPTH) mInitDone = 1;
`else
        checkOutput("init_sram_ce", sram_ce, 0);
        mInitDone = 1;
`endif
      end else begin
        anyG = req0_valid || req1_valid;
        win  = (req0_valid && req1_valid) ? mPtr : req1_valid;
        checkOutput("req0_ready", req0_ready, anyG && !win);
        checkOutput("req1_ready", req1_ready, anyG && win);
        checkOutput("sram_ce", sram_ce, anyG);
        if (anyG) begin
          ww = win ? req1_we : req0_we;
          wm = win ? req1_wmask : req0_wmask;
          wa = win ? req1_addr : req0_addr;
          wd = win ? req1_din : req0_din;
          checkOutput("sram_we", sram_we, ww);
          checkOutput("sram_addr", sram_addr, wa);
          if (ww) begin
            checkOutput("sram_wmask", sram_wmask, wm);
            checkOutput("sram_din", sram_din, wd);
            mMem[wa] = (mMem[wa] & ~wm) | (wd & wm);
            mKnown[wa] = mKnown[wa] || (wm == 8'hFF);
          end else begin
            nPV = 1; nPP = win; nPK = mKnown[wa]; nPD = mMem[wa];
          end
          mPtr = !win;
        end
      end
      mPendV = nPV; mPendPort = nPP; mPendKnown = nPK; mPendData = nPD;
    end
  end

  initial begin
    int   lowCycles, readyLeak, nG, prevG;
    bit   seen;
    int   grants [4];
    rst = 1'b1;
    applyStimulus(0, 1'b0, 1'b0, 8'h00, 10'h000, 8'h00);
    applyStimulus(1, 1'b0, 1'b0, 8'h00, 10'h000, 8'h00);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    applyStimulus(0, 1'b1, 1'b0, 8'hFF, 10'h123, 8'h00);

    // Requests held during initialisation must wait for init_done.
    lowCycles = 0; readyLeak = 0; seen = 0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(negedge clk);
      if (init_done) seen = 1;
      else begin
        lowCycles++;
        if (req0_ready || req1_ready) readyLeak++;
      end
    end
    checkOutput("init_done_seen", seen, 1);
    checkOutput("init_latency", lowCycles, INIT_CYCLES);
    checkOutput("ready_during_init", readyLeak, 0);
    @(posedge clk); #1;
    applyStimulus(0, 1'b0, 1'b0, 8'h00, 10'h000, 8'h00);
    @(negedge clk);
    checkOutput("post_init_rsp0_valid", rsp0_valid, 1);
`ifdef SRAM22_ARB_INIT_EN
    checkOutput("post_init_rdata_zero", rsp0_rdata, 8'h00);
`endif

    // Port 0 write then read back.
    singleXfer("t1_wr_ready", 0, 1'b1, 8'hFF, 10'h005, 8'hA5);
    singleXfer("t1_rd_ready", 0, 1'b0, 8'hFF, 10'h005, 8'h00);
    @(negedge clk);
    checkOutput("t1_rsp0_valid", rsp0_valid, 1);
    checkOutput("t1_rsp0_rdata", rsp0_rdata, 8'hA5);
    checkOutput("t1_rsp1_quiet", rsp1_valid, 0);
    @(negedge clk);
    checkOutput("t1_rsp0_single", rsp0_valid, 0);
    checkOutput("t1_rdata_held", rsp0_rdata, 8'hA5);

    // Port 1 masked write on the top word.
    singleXfer("t3_clr_ready", 1, 1'b1, 8'hFF, 10'h3FF, 8'h00);
    singleXfer("t3_wr_ready", 1, 1'b1, 8'h0F, 10'h3FF, 8'hFF);
    singleXfer("t3_rd_ready", 1, 1'b0, 8'hFF, 10'h3FF, 8'h00);
    @(negedge clk);
    checkOutput("t3_rsp1_valid", rsp1_valid, 1);
    checkOutput("t3_rsp1_rdata", rsp1_rdata, 8'h0F);
    checkOutput("t3_rsp0_quiet", rsp0_valid, 0);

    // Reset lands while a port 0 read is in flight.
    @(posedge clk); #1;
    applyStimulus(0, 1'b1, 1'b0, 8'hFF, 10'h005, 8'h00);
    @(negedge clk);
    checkOutput("t4_rd_ready", req0_ready, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    applyStimulus(0, 1'b1, 1'b0, 8'hFF, 10'h010, 8'h00);
    applyStimulus(1, 1'b1, 1'b0, 8'hFF, 10'h020, 8'h00);
    @(negedge clk);
    checkOutput("t4_rsp_dropped", rsp0_valid, 0);
    checkOutput("t4_ce_low", sram_ce, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("t4_init_done_low", init_done, 0);
`ifdef SRAM22_ARB_INIT_EN
    checkOutput("t4_init_restart_ce", sram_ce, 1);
    checkOutput("t4_init_restart_addr", sram_addr, 0);
`endif

    // Both ports valid every cycle: grants must alternate from port 0.
    nG = 0; prevG = -1;
    for (int i = 0; i < 3000 && nG < 4; i++) begin
      if (prevG >= 0) checkOutput("t2_rsp_follows", (prevG == 1) ? rsp1_valid : rsp0_valid, 1);
      prevG = -1;
      if (req0_ready) begin grants[nG] = 0; nG++; prevG = 0; end
      else if (req1_ready) begin grants[nG] = 1; nG++; prevG = 1; end
      if (nG < 4) @(negedge clk);
    end
    checkOutput("t2_grant_count", nG, 4);
    @(posedge clk); #1;
    applyStimulus(0, 1'b0, 1'b0, 8'h00, 10'h000, 8'h00);
    applyStimulus(1, 1'b0, 1'b0, 8'h00, 10'h000, 8'h00);
    @(negedge clk);
    if (prevG >= 0) checkOutput("t2_last_rsp", (prevG == 1) ? rsp1_valid : rsp0_valid, 1);
    checkOutput("t2_grant0", grants[0], 0);
    checkOutput("t2_grant1", grants[1], 1);
    checkOutput("t2_grant2", grants[2], 0);
    checkOutput("t2_grant3", grants[3], 1);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
